stream_demux2: RTL and testbench

- Parameterized N-bit 1:2 stream demultiplexer with valid/ready handshake; the steering counterpart of the 2:1 data mux.
- Routes each input packet (one or more beats, terminated by last) to output 0 or 1.
- The destination is selected on the first beat and locked until the last beat.
- Each output has a one-entry registered stage, so the two consumers stall independently and outputs are glitch-free.

---
 rtl/stream_demux2_pkg.sv | 8 +
 rtl/stream_demux2_if.sv | 39 +++
 rtl/stream_demux2_reg.sv | 35 +++
 rtl/stream_demux2.sv | 110 +++++++++++
 tb/tb_stream_demux2.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux2_pkg.sv
// Shared types and defaults for the stream_demux2 1:2 packet demultiplexer.
package stream_demux_pkg;

  typedef enum logic {S_IDLE, S_LOCKED} demux_state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/stream_demux2_if.sv
// Valid/ready bundle for stream_demux2: one input stream and two output streams.
interface stream_demux2_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_sel;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_last;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_last;
  logic             out1_ready;

  modport master (
    output in_data, in_valid, in_last, in_sel,
    input  in_ready,
    input  out0_data, out0_valid, out0_last,
    output out0_ready,
    input  out1_data, out1_valid, out1_last,
    output out1_ready
  );

  modport slave (
    input  in_data, in_valid, in_last, in_sel,
    output in_ready,
    output out0_data, out0_valid, out0_last,
    input  out0_ready,
    output out1_data, out1_valid, out1_last,
    input  out1_ready
  );

endinterface

// File: rtl/stream_demux2_reg.sv
// One-entry registered valid/ready stage; 'free' reports it can take a beat this cycle.
module stream_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         vld,
  input  logic         ready,
  output logic         free
);

  logic [W-1:0] data_p1;
  logic         vld_p1;

  assign free = !vld_p1 || ready;
  assign dout = data_p1;
  assign vld  = vld_p1;

  // Stage boundary: load takes priority over drain so a simultaneous drain+load keeps valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      data_p1 <= din;
      vld_p1  <= 1'b1;
    end else if (ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux2.sv
// 1:2 packet stream demultiplexer; destination locked from first to last beat.
// Optional per-output delivered-beat counters with `define STREAM_DEMUX_CNT_EN.
module stream_demux2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef STREAM_DEMUX_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  stream_demux2_if.slave     s,
  output logic               busy
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
`endif
);

  demux_state_e state, state_nxt;
  logic         lock_sel, lock_sel_nxt;
  logic         tgt;
  logic         free0, free1;
  logic         accept;
  logic [WIDTH:0] beat_p0;
  logic [WIDTH:0] dout0, dout1;

  // in_sel is only honoured on a first beat; mid-packet the locked target wins.
  assign tgt      = (state == S_IDLE) ? s.in_sel : lock_sel;
  assign s.in_ready = tgt ? free1 : free0;
  assign accept   = s.in_valid && s.in_ready;
  assign beat_p0  = {s.in_data, s.in_last};

  stream_reg #(.W(WIDTH + 1)) u_stage0 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept && !tgt),
    .din     (beat_p0),
    .dout    (dout0),
    .vld     (s.out0_valid),
    .ready   (s.out0_ready),
    .free    (free0)
  );

  stream_reg #(.W(WIDTH + 1)) u_stage1 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept && tgt),
    .din     (beat_p0),
    .dout    (dout1),
    .vld     (s.out1_valid),
    .ready   (s.out1_ready),
    .free    (free1)
  );

  assign s.out0_data = dout0[WIDTH:1];
  assign s.out0_last = dout0[0];
  assign s.out1_data = dout1[WIDTH:1];
  assign s.out1_last = dout1[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      lock_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_sel_nxt = lock_sel;
    case (state)
      S_IDLE: begin
        if (accept && !s.in_last) begin
          state_nxt    = S_LOCKED;
          lock_sel_nxt = s.in_sel;
        end
      end
      S_LOCKED: begin
        if (accept && s.in_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_LOCKED);

`ifdef STREAM_DEMUX_CNT_EN
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  // Counters advance on drains, i.e. beats actually taken by the consumer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (s.out0_valid && s.out0_ready) cnt0 <= cnt_inc(cnt0);
      if (s.out1_valid && s.out1_ready) cnt1 <= cnt_inc(cnt1);
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Directed self-checking bench for stream_demux2 (counters checked when STREAM_DEMUX_CNT_EN is defined).
module tb_stream_demux2;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic clk;
  logic reset_n;
  logic busy;
`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0, cnt1;
  logic [CNT_W-1:0] base0, base1;
`endif

  int checks   = 0;
  int failures = 0;
  int delivered;

  stream_demux2_if #(.WIDTH(WIDTH)) bus ();

`ifdef STREAM_DEMUX_CNT_EN
  stream_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .s(bus), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );
`else
  stream_demux2 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .s(bus), .busy(busy)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [7:0] d, input logic last);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.in_last  = last;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      bus.out0_ready = 1'($urandom);
      bus.out1_ready = 1'($urandom);
      tick();
      check("rst_out0_valid", bus.out0_valid, 0);
      check("rst_out1_valid", bus.out1_valid, 0);
      check("rst_busy", busy, 0);
    end
    check("rst_out0_data", bus.out0_data, 0);
    check("rst_out1_last", bus.out1_last, 0);
`ifdef STREAM_DEMUX_CNT_EN
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
`endif
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    reset_n = 1'b1;
    tick();

    // X on select/data while idle must not change state
    bus.in_sel  = 1'bx;
    bus.in_data = 'x;
    tick();
    check("x_busy", busy, 0);
    check("x_out0_valid", bus.out0_valid, 0);
    check("x_out1_valid", bus.out1_valid, 0);

    // Single beat to out1
    drive(1'b1, 1'b1, 8'hA5, 1'b1);
    #1 check("single_in_ready", bus.in_ready, 1);
    tick();
    check("single_out1_valid", bus.out1_valid, 1);
    check("single_out1_data", bus.out1_data, 8'hA5);
    check("single_out1_last", bus.out1_last, 1);
    check("single_out0_valid", bus.out0_valid, 0);
    check("single_busy", busy, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("single_drain", bus.out1_valid, 0);

    // Locked packet: select toggles mid-packet but beats stay on out0
    drive(1'b1, 1'b0, 8'h11, 1'b0);
    tick();
    check("lock_b1_data", bus.out0_data, 8'h11);
    check("lock_b1_busy", busy, 1);
    drive(1'b1, 1'b1, 8'h22, 1'b0);
    tick();
    check("lock_b2_data", bus.out0_data, 8'h22);
    check("lock_b2_out1_valid", bus.out1_valid, 0);
    check("lock_b2_busy", busy, 1);
    drive(1'b1, 1'b1, 8'h33, 1'b1);
    tick();
    check("lock_b3_data", bus.out0_data, 8'h33);
    check("lock_b3_last", bus.out0_last, 1);
    check("lock_b3_out1_valid", bus.out1_valid, 0);
    check("lock_b3_busy", busy, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("lock_drain", bus.out0_valid, 0);

    // Backpressure on out0 during a 2-beat packet
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'hB1, 1'b0);
    tick();
    check("bp_b1_valid", bus.out0_valid, 1);
    check("bp_busy", busy, 1);
    drive(1'b1, 1'b1, 8'hB2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1 check("bp_in_ready", bus.in_ready, 0);
      tick();
      check("bp_hold_data", bus.out0_data, 8'hB1);
      check("bp_hold_valid", bus.out0_valid, 1);
      check("bp_out1_valid", bus.out1_valid, 0);
    end
    bus.out0_ready = 1'b1;
    #1 check("bp_release_ready", bus.in_ready, 1);
    tick();
    check("bp_b2_data", bus.out0_data, 8'hB2);
    check("bp_b2_last", bus.out0_last, 1);
    check("bp_b2_busy", busy, 0);
    drive(1'b1, 1'b1, 8'hC1, 1'b1);
    tick();
    check("bp_next_out1_data", bus.out1_data, 8'hC1);
    check("bp_next_out1_valid", bus.out1_valid, 1);
    check("bp_out0_drained", bus.out0_valid, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();

    // Throughput: 8 alternating single-beat packets
`ifdef STREAM_DEMUX_CNT_EN
    base0 = cnt0;
    base1 = cnt1;
`endif
    delivered = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'(i % 2), 8'(8'h40 + i), 1'b1);
      #1 check("tp_in_ready", bus.in_ready, 1);
      tick();
      if (i % 2 == 1) check("tp_out1_data", bus.out1_data, 8'h40 + i);
      else            check("tp_out0_data", bus.out0_data, 8'h40 + i);
      delivered += int'(bus.out0_valid) + int'(bus.out1_valid);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("tp_valid_beats", delivered, 8);
    check("tp_done_out0", bus.out0_valid, 0);
    check("tp_done_out1", bus.out1_valid, 0);
`ifdef STREAM_DEMUX_CNT_EN
    check("tp_cnt0", cnt0 - base0, 4);
    check("tp_cnt1", cnt1 - base1, 4);
`endif

    // Reset mid-packet
    drive(1'b1, 1'b1, 8'hD1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'hD2, 1'b0);
    tick();
    check("mid_out1_data", bus.out1_data, 8'hD2);
    check("mid_busy", busy, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out1_valid", bus.out1_valid, 0);
    check("mid_rst_out1_data", bus.out1_data, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 8'hE7, 1'b1);
    tick();
    check("post_out0_valid", bus.out0_valid, 1);
    check("post_out0_data", bus.out0_data, 8'hE7);
    check("post_out1_valid", bus.out1_valid, 0);
    check("post_busy", busy, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
